// File: rtl/tlk2711_pkg.sv
// rtl/tlk2711_pkg.sv - shared types and constants for the TLK2711 link controller
//
// Holds the controller state encoding (also exported on o_state for debug),
// the i_mode and o_tx_sel codes, the default timing constants and the
// helper that turns a cycle count into a down-counter load value.
package tlk2711_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PWRUP = 3'd1,
    ST_LOCK  = 3'd2,
    ST_SYNC  = 3'd3,
    ST_RUN   = 3'd4,
    ST_STOP  = 3'd5,
    ST_FAIL  = 3'd6
  } state_t;

  localparam logic [2:0] MODE_NORMAL   = 3'd0;
  localparam logic [2:0] MODE_LOOPBACK = 3'd1;
  localparam logic [2:0] MODE_PRBS     = 3'd2;
  localparam logic [2:0] MODE_TEST     = 3'd3;

  localparam logic [1:0] TX_ZERO  = 2'd0;
  localparam logic [1:0] TX_COMMA = 2'd1;
  localparam logic [1:0] TX_USER  = 2'd2;

  localparam int DEF_PWRUP_CYC = 8000;
  localparam int DEF_LOCK_CYC  = 4000;
  localparam int DEF_SYNC_CYC  = 1024;
  localparam int DEF_SYNC_CNT  = 16;
  localparam int DEF_LOS_LIMIT = 255;
  localparam int DEF_RETRY_MAX = 3;
  localparam int DEF_DRAIN_CYC = 16;

  // A state that must last N cycles loads N-1 and leaves when the counter
  // reads zero; N = 0 collapses to a single-cycle stay.
  function automatic logic [15:0] timer_load(input int cyc);
    return (cyc <= 0) ? 16'd0 : 16'(cyc - 1);
  endfunction

endpackage

// File: rtl/tlk2711_timer.sv
// rtl/tlk2711_timer.sv - loadable 16-bit down-counter with zero flag
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       load load_val this cycle (takes priority over counting)
//   load_val   value loaded into the counter
//   done       counter currently reads zero
module tlk2711_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        done
);

  logic [15:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 16'd0) begin
      count <= count - 16'd1;
    end
  end

  assign done = (count == 16'd0);

endmodule

// File: rtl/tlk2711_link_ctrl.sv
// rtl/tlk2711_link_ctrl.sv - TLK2711 per-channel bring-up and link supervision
//
// Sequences one TLK2711 through power-up, reference lock and comma sync,
// then supervises the receive side for loss of sync. Shutdown is a
// start/stop/ack handshake with a comma drain before the part is disabled.
//
// Ports:
//   clk, rst        80 MHz clock, asynchronous active-high reset
//   i_start         level, honoured only in IDLE
//   i_stop          level, shutdown request (wins over everything)
//   i_mode          0 normal, 1 loopback, 2 prbs, 3 test; 4-7 rejected
//   i_rx_comma      1-cycle K28.5 seen pulse
//   i_rx_err        1-cycle RX code/PRBS error pulse
//   o_stop_ack      1-cycle pulse when shutdown completes
//   o_busy          not IDLE
//   o_link_up       in RUN
//   o_err           sticky error (FAIL or rejected mode)
//   o_err_cnt       saturating RX error count while in RUN
//   o_tx_sel        TX payload select: 0 zero, 1 comma/idle, 2 user data
//   o_enable .. o_testen  TLK2711 control pins
//   o_state         debug state encoding
module tlk2711_link_ctrl
  import tlk2711_pkg::*;
#(
  parameter int PWRUP_CYC = DEF_PWRUP_CYC,
  parameter int LOCK_CYC  = DEF_LOCK_CYC,
  parameter int SYNC_CYC  = DEF_SYNC_CYC,
  parameter int SYNC_CNT  = DEF_SYNC_CNT,
  parameter int LOS_LIMIT = DEF_LOS_LIMIT,
  parameter int RETRY_MAX = DEF_RETRY_MAX,
  parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [2:0]  i_mode,
  input  logic        i_rx_comma,
  input  logic        i_rx_err,
  output logic        o_stop_ack,
  output logic        o_busy,
  output logic        o_link_up,
  output logic        o_err,
  output logic [15:0] o_err_cnt,
  output logic [1:0]  o_tx_sel,
  output logic        o_enable,
  output logic        o_lckrefn,
  output logic        o_loopen,
  output logic        o_prbsen,
  output logic        o_testen,
  output logic [2:0]  o_state
);

  state_t      state_q, state_d;
  logic [2:0]  mode_q, mode_d;
  logic [8:0]  retry_q, retry_d, retry_next;
  logic [15:0] comma_q, comma_d, comma_next;
  logic [15:0] los_q, los_d, los_next;

  logic        err_d, ack_d, busy_d, link_up_d;
  logic [15:0] err_cnt_d;
  logic [1:0]  tx_sel_d;
  logic        enable_d, lckrefn_d, loopen_d, prbsen_d, testen_d;

  logic        timer_load_en;
  logic [15:0] timer_val;
  logic        timer_done;

  // One timer serves every timed state; in SYNC it is the sync window.
  tlk2711_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load_en),
    .load_val (timer_val),
    .done     (timer_done)
  );

  assign timer_load_en = (state_d != state_q);

  always_comb begin
    timer_val = 16'd0;
    case (state_d)
      ST_PWRUP: timer_val = timer_load(PWRUP_CYC);
      ST_LOCK:  timer_val = timer_load(LOCK_CYC);
      ST_SYNC:  timer_val = timer_load(SYNC_CYC);
      ST_STOP:  timer_val = timer_load(DRAIN_CYC);
      default:  timer_val = 16'd0;
    endcase
  end

  // Next-state and bookkeeping.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    retry_d    = retry_q;
    comma_d    = comma_q;
    los_d      = los_q;
    err_d      = o_err;
    err_cnt_d  = o_err_cnt;
    ack_d      = 1'b0;
    comma_next = comma_q + 16'(i_rx_comma);
    los_next   = i_rx_comma ? 16'd0 :
                 ((los_q == 16'hFFFF) ? los_q : los_q + 16'd1);
    retry_next = retry_q + 9'd1;

    if (state_q == ST_RUN && i_rx_err && o_err_cnt != 16'hFFFF) begin
      err_cnt_d = o_err_cnt + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_stop) begin
          ack_d = 1'b1;
        end else if (i_start) begin
          if (i_mode <= MODE_TEST) begin
            mode_d    = i_mode;
            err_d     = 1'b0;
            err_cnt_d = 16'd0;
            retry_d   = 9'd0;
            state_d   = ST_PWRUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PWRUP: if (timer_done) state_d = ST_LOCK;
      ST_LOCK:  if (timer_done) state_d = ST_SYNC;
      ST_SYNC: begin
        comma_d = comma_next;
        // Enough commas beats a window expiring in the same cycle.
        if (comma_next >= 16'(SYNC_CNT)) begin
          state_d = ST_RUN;
        end else if (timer_done) begin
          retry_d = retry_next;
          state_d = (retry_next > 9'(RETRY_MAX)) ? ST_FAIL : ST_LOCK;
        end
      end
      ST_RUN: begin
        los_d = los_next;
        if (mode_q != MODE_PRBS && los_next >= 16'(LOS_LIMIT)) begin
          state_d = ST_SYNC;
        end
      end
      ST_STOP: begin
        if (timer_done) begin
          ack_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_IDLE;
    endcase

    if (i_stop && state_q != ST_IDLE && state_q != ST_STOP) begin
      state_d = ST_STOP;
    end

    if (state_d == ST_SYNC && state_q != ST_SYNC) begin
      comma_d = 16'd0;
    end
    if (state_d == ST_RUN && state_q != ST_RUN) begin
      los_d   = 16'd0;
      retry_d = 9'd0;
    end
    if (state_d == ST_FAIL) begin
      err_d = 1'b1;
    end
  end

  // Pin decode from the state being entered, so pins register with it.
  always_comb begin
    busy_d    = (state_d != ST_IDLE);
    link_up_d = 1'b0;
    tx_sel_d  = TX_ZERO;
    enable_d  = 1'b0;
    lckrefn_d = 1'b0;
    loopen_d  = 1'b0;
    prbsen_d  = 1'b0;
    testen_d  = 1'b0;
    case (state_d)
      ST_PWRUP: enable_d = 1'b1;
      ST_LOCK: begin
        enable_d = 1'b1;
        tx_sel_d = TX_COMMA;
      end
      ST_SYNC: begin
        enable_d  = 1'b1;
        lckrefn_d = 1'b1;
        tx_sel_d  = TX_COMMA;
        loopen_d  = (mode_q == MODE_LOOPBACK);
      end
      ST_RUN: begin
        enable_d  = 1'b1;
        lckrefn_d = 1'b1;
        link_up_d = 1'b1;
        tx_sel_d  = TX_USER;
        case (mode_q)
          MODE_NORMAL:   ;
          MODE_LOOPBACK: loopen_d = 1'b1;
          MODE_PRBS: begin
            prbsen_d = 1'b1;
            tx_sel_d = TX_COMMA;
          end
          MODE_TEST:     testen_d = 1'b1;
          default:       ;
        endcase
      end
      // The reference-lock pin is left where it was while draining or failed.
      ST_STOP, ST_FAIL: begin
        enable_d  = 1'b1;
        lckrefn_d = o_lckrefn;
        tx_sel_d  = TX_COMMA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= 3'd0;
      retry_q    <= 9'd0;
      comma_q    <= 16'd0;
      los_q      <= 16'd0;
      o_stop_ack <= 1'b0;
      o_busy     <= 1'b0;
      o_link_up  <= 1'b0;
      o_err      <= 1'b0;
      o_err_cnt  <= 16'd0;
      o_tx_sel   <= TX_ZERO;
      o_enable   <= 1'b0;
      o_lckrefn  <= 1'b0;
      o_loopen   <= 1'b0;
      o_prbsen   <= 1'b0;
      o_testen   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      retry_q    <= retry_d;
      comma_q    <= comma_d;
      los_q      <= los_d;
      o_stop_ack <= ack_d;
      o_busy     <= busy_d;
      o_link_up  <= link_up_d;
      o_err      <= err_d;
      o_err_cnt  <= err_cnt_d;
      o_tx_sel   <= tx_sel_d;
      o_enable   <= enable_d;
      o_lckrefn  <= lckrefn_d;
      o_loopen   <= loopen_d;
      o_prbsen   <= prbsen_d;
      o_testen   <= testen_d;
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_tlk2711_link_ctrl.sv
// tb/tb_tlk2711_link_ctrl.sv - scoreboard bench for tlk2711_link_ctrl
module tb_tlk2711_link_ctrl;

  localparam int P_PWRUP = 10;
  localparam int P_LOCK  = 10;
  localparam int P_SYNC  = 32;
  localparam int P_CNT   = 4;
  localparam int P_LOS   = 8;
  localparam int P_RETRY = 2;
  localparam int P_DRAIN = 4;

  localparam int PH_IDLE = 0, PH_PWRUP = 1, PH_LOCK = 2, PH_SYNC = 3,
                 PH_RUN = 4, PH_STOP = 5, PH_FAIL = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, comma = 1'b0, rx_err = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic        stop_ack, busy, link_up, err;
  logic [15:0] err_cnt;
  logic [1:0]  tx_sel;
  logic        enable, lckrefn, loopen, prbsen, testen;
  logic [2:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  tlk2711_link_ctrl #(
    .PWRUP_CYC (P_PWRUP), .LOCK_CYC (P_LOCK), .SYNC_CYC (P_SYNC),
    .SYNC_CNT  (P_CNT),   .LOS_LIMIT (P_LOS), .RETRY_MAX (P_RETRY),
    .DRAIN_CYC (P_DRAIN)
  ) dut (
    .clk (clk), .rst (rst), .i_start (start), .i_stop (stop), .i_mode (mode),
    .i_rx_comma (comma), .i_rx_err (rx_err), .o_stop_ack (stop_ack),
    .o_busy (busy), .o_link_up (link_up), .o_err (err), .o_err_cnt (err_cnt),
    .o_tx_sel (tx_sel), .o_enable (enable), .o_lckrefn (lckrefn),
    .o_loopen (loopen), .o_prbsen (prbsen), .o_testen (testen),
    .o_state (state)
  );

  always #5 clk = ~clk;

  // Reference model: phase, cycles spent in it, and the counters the rules need.
  int  m_phase, m_e, m_commas, m_retries, m_quiet, m_mode, m_err_cnt;
  bit  m_err, m_lck, m_ack;
  logic [29:0] exp_q[$];

  function automatic int dur(input int n);
    return (n <= 0) ? 1 : n;
  endfunction

  function automatic void m_reset();
    m_phase = PH_IDLE; m_e = 0; m_commas = 0; m_retries = 0; m_quiet = 0;
    m_mode = 0; m_err_cnt = 0; m_err = 0; m_lck = 0; m_ack = 0;
  endfunction

  function automatic void m_enter(input int p);
    m_phase = p; m_e = 0; m_commas = 0; m_quiet = 0;
    if (p == PH_RUN) m_retries = 0;
    if (p == PH_FAIL) m_err = 1'b1;
  endfunction

  function automatic void m_step(input bit st, input bit sp, input int md,
                                 input bit cm, input bit er);
    m_ack = 1'b0;
    if (m_phase == PH_RUN && er && m_err_cnt < 65535) m_err_cnt++;
    if (m_phase == PH_IDLE) begin
      if (sp) m_ack = 1'b1;
      else if (st) begin
        if (md <= 3) begin
          m_mode = md; m_err = 0; m_err_cnt = 0; m_retries = 0;
          m_enter(PH_PWRUP);
        end else m_err = 1'b1;
      end
    end else if (sp && m_phase != PH_STOP) begin
      m_enter(PH_STOP);
    end else begin
      m_e++;
      case (m_phase)
        PH_PWRUP: if (m_e >= dur(P_PWRUP)) m_enter(PH_LOCK);
        PH_LOCK:  if (m_e >= dur(P_LOCK)) m_enter(PH_SYNC);
        PH_SYNC: begin
          m_commas += int'(cm);
          if (m_commas >= P_CNT) m_enter(PH_RUN);
          else if (m_e >= dur(P_SYNC)) begin
            m_retries++;
            m_enter((m_retries > P_RETRY) ? PH_FAIL : PH_LOCK);
          end
        end
        PH_RUN: begin
          m_quiet = cm ? 0 : m_quiet + 1;
          if (m_mode != 2 && m_quiet >= P_LOS) m_enter(PH_SYNC);
        end
        PH_STOP: if (m_e >= dur(P_DRAIN)) begin
          m_enter(PH_IDLE);
          m_ack = 1'b1;
        end
        default: ;
      endcase
    end
    if (m_phase == PH_IDLE || m_phase == PH_PWRUP || m_phase == PH_LOCK) m_lck = 0;
    else if (m_phase == PH_SYNC || m_phase == PH_RUN) m_lck = 1;
  endfunction

  function automatic logic [29:0] m_snapshot();
    bit run, syn;
    logic [1:0] tx;
    run = (m_phase == PH_RUN);
    syn = (m_phase == PH_SYNC);
    if (m_phase == PH_IDLE || m_phase == PH_PWRUP) tx = 2'd0;
    else if (run && m_mode != 2) tx = 2'd2;
    else tx = 2'd1;
    return {m_ack, m_phase != PH_IDLE, run, m_err, 16'(m_err_cnt), tx,
            m_phase != PH_IDLE, m_lck, (m_mode == 1) && (syn || run),
            (m_mode == 2) && run, (m_mode == 3) && run, 3'(m_phase)};
  endfunction

  function automatic logic [29:0] dut_snapshot();
    return {stop_ack, busy, link_up, err, err_cnt, tx_sel, enable, lckrefn,
            loopen, prbsen, testen, state};
  endfunction

  // Model steps on every clock edge (or resets asynchronously) and queues
  // the outputs expected for the following cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reset();
      exp_q.delete();
      if (clk) exp_q.push_back(m_snapshot());
    end else begin
      m_step(start, stop, int'(mode), comma, rx_err);
      exp_q.push_back(m_snapshot());
    end
  end

  // Monitor: pops one expectation per cycle and compares away from the edge.
  always @(negedge clk) begin
    logic [29:0] exp;
    exp = '0;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else if (!rst) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_underflow @%0t no expectation queued", $time);
    end
    if (rst) exp = '0;
    n_tests++;
    if (dut_snapshot() !== exp) begin
      n_fail++;
      $display("FAIL scoreboard @%0t got=%h expected=%h", $time, dut_snapshot(), exp);
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) begin
      comma = 1'b1; tick(); comma = 1'b0;
      if (i < n - 1) tick();
    end
  endtask

  task automatic pulse_start(input logic [2:0] md);
    start = 1'b1; mode = md; tick(); start = 1'b0;
  endtask

  task automatic random_episodes(input int n);
    for (int ep = 0; ep < n; ep++) begin
      int p, len;
      logic [2:0] md;
      md  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: p = 0;
        1: p = 6;
        2: p = 20;
        default: p = 50;
      endcase
      len = $urandom_range(60, 220);
      pulse_start(md);
      for (int c = 0; c < len; c++) begin
        comma  = ($urandom_range(0, 99) < p);
        rx_err = ($urandom_range(0, 15) == 0);
        start  = ($urandom_range(0, 31) == 0);
        stop   = ($urandom_range(0, 199) == 0);
        mode   = 3'($urandom_range(0, 7));
        tick();
      end
      comma = 0; rx_err = 0; start = 0;
      stop = 1'b1; tick(); stop = 1'b0;
      cyc(8);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    check("reset_state", int'(dut_snapshot()), 0);
    rst = 1'b0;
    cyc(2);

    // Normal bring-up
    pulse_start(3'd0);
    check("bringup_enable", int'(enable), 1);
    check("bringup_busy", int'(busy), 1);
    cyc(19);
    check("lckrefn_before_sync", int'(lckrefn), 0);
    tick();
    check("lckrefn_at_sync", int'(lckrefn), 1);
    check("state_sync", int'(state), PH_SYNC);
    send_commas(4);
    check("link_up_after_4th", int'(link_up), 1);
    check("tx_sel_user", int'(tx_sel), 2);

    // Loss of sync and recovery
    cyc(7);
    check("link_up_los_minus1", int'(link_up), 1);
    tick();
    check("link_down_los", int'(link_up), 0);
    check("state_after_los", int'(state), PH_SYNC);
    send_commas(4);
    check("link_up_resync", int'(link_up), 1);

    // Stop from RUN
    stop = 1'b1; tick(); stop = 1'b0;
    check("state_stop", int'(state), PH_STOP);
    cyc(3);
    check("ack_not_early", int'(stop_ack), 0);
    tick();
    check("ack_after_drain", int'(stop_ack), 1);
    check("enable_off_after_drain", int'(enable), 0);
    tick();
    check("ack_one_cycle", int'(stop_ack), 0);

    // Sync failure: three windows without commas
    pulse_start(3'd0);
    cyc(51);
    check("first_window_open", int'(state), PH_SYNC);
    tick();
    check("retry_to_lock", int'(state), PH_LOCK);
    cyc(83);
    check("third_window_open", int'(state), PH_SYNC);
    tick();
    check("state_fail", int'(state), PH_FAIL);
    check("err_in_fail", int'(err), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    cyc(3);
    tick();
    check("fail_stop_ack", int'(stop_ack), 1);
    check("fail_stop_enable", int'(enable), 0);
    check("err_sticky", int'(err), 1);
    cyc(2);

    // PRBS mode
    pulse_start(3'd2);
    check("err_cleared_on_start", int'(err), 0);
    cyc(20);
    send_commas(4);
    check("prbs_prbsen", int'(prbsen), 1);
    check("prbs_tx_sel", int'(tx_sel), 1);
    cyc(100);
    check("prbs_no_los", int'(link_up), 1);
    repeat (3) begin
      rx_err = 1'b1; tick(); rx_err = 1'b0; tick();
    end
    check("prbs_err_cnt", int'(err_cnt), 3);
    stop = 1'b1; tick(); stop = 1'b0;
    cyc(6);

    // Illegal mode, then start/stop contention in IDLE
    pulse_start(3'd5);
    check("illegal_err", int'(err), 1);
    check("illegal_state", int'(state), PH_IDLE);
    start = 1'b1; stop = 1'b1; mode = 3'd0; tick(); start = 1'b0; stop = 1'b0;
    check("contention_ack", int'(stop_ack), 1);
    check("contention_busy", int'(busy), 0);
    tick();

    // Asynchronous reset in RUN (test mode)
    pulse_start(3'd3);
    cyc(20);
    send_commas(4);
    check("test_mode_testen", int'(testen), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", int'(dut_snapshot()), 0);
    tick();
    rst = 1'b0;
    tick();
    check("after_reset_idle", int'(state), PH_IDLE);

    random_episodes(25);

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tlk2711_link_ctrl.md
Name: tlk2711_link_ctrl

Overview:
Per-channel bring-up and link-supervision controller for one TLK2711 SerDes. It drives the device control pins (enable, lckrefn, loopen, prbsen, testen) through power-up, reference lock and comma synchronisation. It then selects the TX payload source and supervises the receive side for loss-of-sync. A start/stop/ack handshake allows it to sit between a VIO or register front end and the tlk2711 datapath.

Parameters:
PWRUP_CYC, 8000, cycles held in power-up after enable asserts (100 us @ 80 MHz)
LOCK_CYC, 4000, cycles with lckrefn low (lock to reference)
SYNC_CYC, 1024, sync window length in cycles
SYNC_CNT, 16, comma pulses required within one sync window
LOS_LIMIT, 255, cycles in RUN without a comma before loss-of-sync
RETRY_MAX, 3, failed sync windows tolerated before FAIL
DRAIN_CYC, 16, comma cycles sent in STOP before disable

Ports:
clk  in  1  single clock domain (80 MHz)
rst  in  1  asynchronous active-high reset
i_start  in  1  level; sampled only in IDLE
i_stop  in  1  level; request shutdown
i_mode  in  3  0 normal, 1 loopback, 2 prbs, 3 test; 4-7 illegal
i_rx_comma  in  1  1-cycle pulse, K28.5 received (already synchronised to clk)
i_rx_err  in  1  1-cycle pulse, RX code/PRBS error (already synchronised)
o_stop_ack  out  1  1-cycle pulse, shutdown complete
o_busy  out  1  high in any state except IDLE
o_link_up  out  1  high only in RUN
o_err  out  1  sticky: FAIL or illegal mode; cleared on next accepted start
o_err_cnt  out  16  saturating i_rx_err count in RUN
o_tx_sel  out  2  0 zero, 1 comma/idle, 2 user data
o_enable, o_lckrefn, o_loopen, o_prbsen, o_testen  out  1 each  TLK2711 control pins
o_state  out  3  debug state encoding

Behaviour:
- All outputs registered. Reset values: all outputs 0, state IDLE, counters 0.
- IDLE: pins and tx_sel 0.
  - i_stop=1 → o_stop_ack pulses next cycle; stop wins over a simultaneous start.
  - i_start=1 with legal mode → latch mode, clear o_err, o_err_cnt and retry count, go to PWRUP.
  - Illegal mode → set o_err, stay in IDLE.
- PWRUP: enable=1, lckrefn=0, tx_sel=0. After PWRUP_CYC cycles → LOCK.
- LOCK: lckrefn=0, tx_sel=1. After LOCK_CYC cycles → SYNC.
- SYNC: lckrefn=1, tx_sel=1, loopen=(mode==1). Window timer and comma counter both restart on entry.
  - Comma count reaches SYNC_CNT → RUN, same cycle the count is met.
  - Window expires first → retry+1, then LOCK if retry ≤ RETRY_MAX, else FAIL.
- RUN: link_up=1, tx_sel=2 (prbs mode: prbsen=1, tx_sel=1; test mode: testen=1). Retry count cleared on entry.
  - Each comma reloads the LOS counter.
  - In normal/loopback/test modes, LOS counter hitting LOS_LIMIT → SYNC, and link_up drops the next cycle.
  - In prbs mode LOS is disabled.
  - i_rx_err increments o_err_cnt, saturating at 0xFFFF.
- FAIL: enable=1, tx_sel=1, o_err=1. Waits for i_stop.
- STOP: entered from any non-IDLE state on i_stop; this takes priority over every other transition.
  - link_up=0, loopen=prbsen=testen=0, tx_sel=1 for DRAIN_CYC cycles.
  - Then enable=0, pulse o_stop_ack, go to IDLE.
  - i_stop deasserting mid-drain does not abort STOP.
- i_start outside IDLE is ignored. Mode changes after latching are ignored until the next IDLE.
- Timers are down-counters loaded on state entry; a zero parameter means a 1-cycle stay.
- rst asserted mid-operation: immediate return to reset values; no ack pulse.

Decomposition:
- Package tlk2711_pkg holds: state enum (IDLE, PWRUP, LOCK, SYNC, RUN, STOP, FAIL = 0-6), mode codes, tx_sel codes, and default timing constants.
- One sub-module, tlk2711_timer: a loadable 16-bit down-counter with a done flag. It is shared for the state timer and the sync window.

Test Plan:
(sim params: PWRUP_CYC=10, LOCK_CYC=10, SYNC_CYC=32, SYNC_CNT=4, LOS_LIMIT=8, RETRY_MAX=2, DRAIN_CYC=4)
- Normal bring-up: start with mode 0, 4 commas in SYNC → enable at +1; lckrefn rises at +21; link_up=1 and tx_sel=2 after the 4th comma.
- Sync failure: start with mode 0, no commas → SYNC→LOCK twice, FAIL after the 3rd window, o_err=1; then stop → ack after 4 drain cycles, enable=0.
- Loss of sync: in RUN, withhold commas 8 cycles → link_up=0, state=SYNC; 4 commas → RUN again.
- PRBS mode: mode 2, reach RUN, no commas for 100 cycles → link_up stays 1, prbsen=1; 3 i_rx_err pulses → o_err_cnt=3.
- Illegal mode and stop/start contention: start with mode 5 → o_err=1, state IDLE; start and stop together in IDLE → ack only, busy=0.
- Async reset in RUN → all outputs 0 the same cycle, no stop_ack.
